// File: rtl/pe_ws_seq_pkg.sv
// Shared types for the weight-stationary PE loop-nest sequencer: FSM states,
// PE ctrl bit positions and the captured job descriptor.
package pe_ws_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int CTRL_RD = 0;
   localparam int CTRL_TM = 3;
   localparam int CTRL_TK = 5;
   localparam int CTRL_TN = 7;

   // Descriptor field width; the sequencer's CNT_WIDTH is expected to match.
   localparam int DESC_W = 8;

   typedef struct packed {
      logic [DESC_W-1:0] len;
      logic [DESC_W-1:0] n;
      logic [DESC_W-1:0] k;
      logic [DESC_W-1:0] m;
   } desc_t;

endpackage

// File: rtl/pe_ws_seq_loop_cnt.sv
// Wrap counter for one level of the loop nest: counts 0..bound-1 on en and
// flags the final value so the next level can be enabled.
module pe_loop_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] bound,
   output logic [W-1:0] value,
   output logic         last
);

   assign last = (value == (bound - W'(1)));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         value <= '0;
      end else if (en) begin
         value <= last ? '0 : value + W'(1);
      end
   end

endmodule

// File: rtl/pe_ws_seq.sv
// Loop-nest sequencer for one weight-stationary PE: loads the weight scratchpad,
// issues ctrl words with rewind flags, drains the MAC pipe and pulses done.
// Optional perf counters are built when PE_WS_SEQ_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for a job descriptor, cfg_ready high
// LOAD  | streaming L*K weights into the PE scratchpad
// RUN   | issuing ctrl words, stalling while iact_valid is low
// DRAIN | letting the MAC pipeline empty before done
module pe_ws_seq
   import pe_ws_seq_pkg::*;
#(
   parameter int OP_WIDTH   = 8,
   parameter int CTRL_WIDTH = 9,
   parameter int ADDR_WIDTH = 10,
   parameter int CNT_WIDTH  = DESC_W,
   parameter int MAC_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CNT_WIDTH-1:0]  cfg_len,
   input  logic [CNT_WIDTH-1:0]  cfg_n,
   input  logic [CNT_WIDTH-1:0]  cfg_k,
   input  logic [CNT_WIDTH-1:0]  cfg_m,
   output logic                  cfg_err,
   input  logic                  w_valid,
   input  logic [OP_WIDTH-1:0]   w_data,
   output logic                  w_ready,
   output logic                  wctrl,
   output logic [OP_WIDTH-1:0]   weight,
   input  logic                  iact_valid,
   output logic                  iact_take,
   output logic [CTRL_WIDTH-1:0] ctrl,
   output logic                  busy,
   output logic                  done
`ifdef PE_WS_SEQ_PERF_EN
   ,
   output logic [31:0]           perf_issue,
   output logic [31:0]           perf_stall
`endif
);

   localparam int PW = 2 * CNT_WIDTH;
   localparam int CW = (PW > ADDR_WIDTH + 1) ? PW : ADDR_WIDTH + 1;
   localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   state_t                 state;
   desc_t                  desc;
   logic [PW-1:0]          load_rem;
   logic [DW-1:0]          drain_rem;
   logic [4*CNT_WIDTH-1:0] loop_end;
   logic [4*CNT_WIDTH-1:0] loop_pos;

   logic                   cfg_hs;
   logic                   cfg_bad;
   logic [PW-1:0]          cfg_prod;
   logic [CW-1:0]          prod_ext;
   logic                   issue;
   logic                   final_issue;
   logic                   en_n, en_k, en_m;
   logic [CNT_WIDTH-1:0]   i_val, n_val, k_val, m_val;
   logic                   i_last, n_last, k_last, m_last;

   assign cfg_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign w_ready   = (state == LOAD);

   assign cfg_hs   = cfg_valid && cfg_ready;
   assign cfg_prod = PW'(cfg_len) * PW'(cfg_k);
   assign prod_ext = CW'(cfg_prod);
   assign cfg_bad  = (cfg_len == '0) || (cfg_n == '0) || (cfg_k == '0) || (cfg_m == '0)
                     || (prod_ext > (CW'(1) << ADDR_WIDTH));

   assign wctrl  = w_valid && w_ready;
   assign weight = wctrl ? w_data : '0;

   assign issue       = (state == RUN) && iact_valid;
   assign en_n        = issue && i_last;
   assign en_k        = en_n && n_last;
   assign en_m        = en_k && k_last;
   assign loop_pos    = {m_val, k_val, n_val, i_val};
   assign final_issue = issue && (loop_pos == loop_end);

   pe_loop_cnt #(.W(CNT_WIDTH)) u_cnt_i (
      .clk(clk), .rst(rst), .clr(cfg_hs), .en(issue),
      .bound(desc.len), .value(i_val), .last(i_last)
   );
   pe_loop_cnt #(.W(CNT_WIDTH)) u_cnt_n (
      .clk(clk), .rst(rst), .clr(cfg_hs), .en(en_n),
      .bound(desc.n), .value(n_val), .last(n_last)
   );
   pe_loop_cnt #(.W(CNT_WIDTH)) u_cnt_k (
      .clk(clk), .rst(rst), .clr(cfg_hs), .en(en_k),
      .bound(desc.k), .value(k_val), .last(k_last)
   );
   pe_loop_cnt #(.W(CNT_WIDTH)) u_cnt_m (
      .clk(clk), .rst(rst), .clr(cfg_hs), .en(en_m),
      .bound(desc.m), .value(m_val), .last(m_last)
   );

   // Flag priority: row reuse rewinds first, then row advance, then full rewind.
   always_comb begin
      ctrl = '0;
      if (issue) begin
         ctrl[CTRL_RD] = 1'b1;
         if (i_last) begin
            if (!n_last)      ctrl[CTRL_TN] = 1'b1;
            else if (!k_last) ctrl[CTRL_TK] = 1'b1;
            else              ctrl[CTRL_TM] = 1'b1;
         end
      end
   end

   assign iact_take = ctrl[CTRL_RD];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         desc      <= '0;
         loop_end  <= '0;
         load_rem  <= '0;
         drain_rem <= '0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cfg_hs) begin
                  desc     <= '{len: cfg_len, n: cfg_n, k: cfg_k, m: cfg_m};
                  loop_end <= {cfg_m - CNT_WIDTH'(1), cfg_k - CNT_WIDTH'(1),
                               cfg_n - CNT_WIDTH'(1), cfg_len - CNT_WIDTH'(1)};
                  if (cfg_bad) begin
                     cfg_err <= 1'b1;
                  end else begin
                     load_rem <= cfg_prod - PW'(1);
                     state    <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (wctrl) begin
                  if (load_rem == '0) state <= RUN;
                  else                load_rem <= load_rem - PW'(1);
               end
            end
            RUN: begin
               if (final_issue) begin
                  drain_rem <= DW'(MAC_LAT - 1);
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_rem == '0) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  drain_rem <= drain_rem - DW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PE_WS_SEQ_PERF_EN
   logic stall;
   assign stall = (state == RUN) && !iact_valid;

   always_ff @(posedge clk) begin
      if (rst || cfg_hs) begin
         perf_issue <= '0;
         perf_stall <= '0;
      end else begin
         if (issue && (perf_issue != '1)) perf_issue <= perf_issue + 32'd1;
         if (stall && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pe_ws_seq.sv
// Scoreboard bench for pe_ws_seq: expected ctrl words and weights are queued
// when a job is driven and popped as the sequencer emits them.
module tb_pe_ws_seq;

   localparam int OPW     = 8;
   localparam int CTW     = 9;
   localparam int AW      = 10;
   localparam int CNTW    = 8;
   localparam int MAC_LAT = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [CNTW-1:0] cfg_len, cfg_n, cfg_k, cfg_m;
   logic            cfg_err;
   logic            w_valid;
   logic [OPW-1:0]  w_data;
   logic            w_ready;
   logic            wctrl;
   logic [OPW-1:0]  weight;
   logic            iact_valid;
   logic            iact_take;
   logic [CTW-1:0]  ctrl;
   logic            busy;
   logic            done;
`ifdef PE_WS_SEQ_PERF_EN
   logic [31:0]     perf_issue, perf_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_wctrl  = 0;
   int n_issue  = 0;
   int n_done   = 0;
   int last_w_cyc     = 0;
   int last_issue_cyc = 0;
   int done_cyc       = 0;
   int iact_mode      = 0;
   int wv_mode        = 0;

   logic [CTW-1:0] cq[$];
   logic [OPW-1:0] wq[$];

   always #5 clk = ~clk;

   pe_ws_seq #(
      .OP_WIDTH(OPW), .CTRL_WIDTH(CTW), .ADDR_WIDTH(AW),
      .CNT_WIDTH(CNTW), .MAC_LAT(MAC_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_len(cfg_len), .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_m(cfg_m),
      .cfg_err(cfg_err),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
      .wctrl(wctrl), .weight(weight),
      .iact_valid(iact_valid), .iact_take(iact_take),
      .ctrl(ctrl), .busy(busy), .done(done)
`ifdef PE_WS_SEQ_PERF_EN
      , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [OPW-1:0] wgen(input int idx);
      return OPW'((idx * 37 + 11) ^ (idx >> 3));
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Input pacing: iact_valid pattern and w_valid gaps, fresh each cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (iact_mode)
            0:       iact_valid = 1'b1;
            1:       iact_valid = (((cyc - last_w_cyc) % 2) == 0);
            default: iact_valid = 1'($urandom_range(0, 1));
         endcase
         w_valid = (wv_mode == 0) ? 1'b1 : ((cyc % 3) != 0);
         w_data  = wgen(n_wctrl);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (wctrl) begin
            n_wctrl++;
            last_w_cyc = cyc;
            if (wq.size() == 0) check_val("wctrl_extra", 32'd1, 32'd0);
            else                check_val("weight", 32'(weight), 32'(wq.pop_front()));
         end
         if (ctrl != '0) begin
            logic [CTW-1:0] e;
            n_issue++;
            last_issue_cyc = cyc;
            if (cq.size() == 0) begin
               check_val("ctrl_extra", 32'(ctrl), 32'd0);
            end else begin
               e = cq.pop_front();
               check_val("ctrl", 32'(ctrl), 32'(e));
               check_val("iact_take", 32'(iact_take), 32'(e[0]));
            end
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   task automatic push_job(input int L, input int N, input int K, input int M);
      for (int m = 0; m < M; m++)
         for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
               for (int i = 0; i < L; i++) begin
                  logic [CTW-1:0] w;
                  w = 9'h001;
                  if (i == L - 1) begin
                     if (n != N - 1)      w = w | 9'h080;
                     else if (k != K - 1) w = w | 9'h020;
                     else                 w = w | 9'h008;
                  end
                  cq.push_back(w);
               end
      for (int j = 0; j < L * K; j++) wq.push_back(wgen(n_wctrl + j));
   endtask

   task automatic send_cfg(input int L, input int N, input int K, input int M);
      @(posedge clk); #1;
      cfg_valid = 1'b1;
      cfg_len = CNTW'(L); cfg_n = CNTW'(N); cfg_k = CNTW'(K); cfg_m = CNTW'(M);
      @(negedge clk);
      check_val("cfg_ready_idle", 32'(cfg_ready), 32'd1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic recover();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cq.delete();
      wq.delete();
   endtask

   task automatic run_job(input int L, input int N, input int K, input int M,
                          input int im, input int wm);
      int w0, i0, d0, budget, total;
      bit got;
      iact_mode = im;
      wv_mode   = wm;
      total = L * N * K * M;
      w0 = n_wctrl; i0 = n_issue; d0 = n_done;
      push_job(L, N, K, M);
      send_cfg(L, N, K, M);
      @(negedge clk);
      check_val("busy_after_cfg", 32'(busy), 32'd1);
      check_val("cfg_ready_busy", 32'(cfg_ready), 32'd0);
      budget = 3 * L * K + 3 * total + 20;
      got = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         @(negedge clk); #1;
         if (done) got = 1'b1;
      end
      if (!got) begin
         check_val("done_timeout", 32'd0, 32'd1);
         recover();
         return;
      end
      check_val("cfg_ready_done", 32'(cfg_ready), 32'd1);
      check_val("busy_done", 32'(busy), 32'd0);
      check_val("n_wctrl", 32'(n_wctrl - w0), 32'(L * K));
      check_val("n_issue", 32'(n_issue - i0), 32'(total));
      check_val("n_done", 32'(n_done - d0), 32'd1);
      check_val("done_lat", 32'(done_cyc - last_issue_cyc), 32'(MAC_LAT + 1));
      check_val("ctrl_left", 32'(cq.size()), 32'd0);
      check_val("w_left", 32'(wq.size()), 32'd0);
      if (im == 0) check_val("run_cycles", 32'(last_issue_cyc - last_w_cyc), 32'(total));
      if (im == 1) check_val("run_cycles", 32'(last_issue_cyc - last_w_cyc), 32'(2 * total));
      @(negedge clk);
      check_val("done_pulse_width", 32'(done), 32'd0);
   endtask

   task automatic err_job(input int L, input int N, input int K, input int M);
      int w0;
      w0 = n_wctrl;
      @(posedge clk); #1;
      cfg_valid = 1'b1;
      cfg_len = CNTW'(L); cfg_n = CNTW'(N); cfg_k = CNTW'(K); cfg_m = CNTW'(M);
      @(negedge clk);
      check_val("cfg_err_early", 32'(cfg_err), 32'd0);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      @(negedge clk);
      check_val("cfg_err_pulse", 32'(cfg_err), 32'd1);
      check_val("err_busy", 32'(busy), 32'd0);
      check_val("err_cfg_ready", 32'(cfg_ready), 32'd1);
      repeat (3) @(negedge clk);
      check_val("cfg_err_clear", 32'(cfg_err), 32'd0);
      check_val("err_busy_later", 32'(busy), 32'd0);
      check_val("err_no_wctrl", 32'(n_wctrl - w0), 32'd0);
   endtask

   task automatic rst_job();
      int i0, d0;
      bit got;
      iact_mode = 0;
      wv_mode   = 0;
      i0 = n_issue; d0 = n_done;
      push_job(2, 2, 2, 1);
      send_cfg(2, 2, 2, 1);
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk); #1;
         if (n_issue - i0 == 3) got = 1'b1;
      end
      if (!got) begin
         check_val("rst_issue_timeout", 32'd0, 32'd1);
         recover();
         return;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_ctrl", 32'(ctrl), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      check_val("rst_done", 32'(done), 32'd0);
      repeat (6) @(negedge clk);
      check_val("rst_no_done", 32'(n_done - d0), 32'd0);
      check_val("rst_no_issue", 32'(n_issue - i0), 32'd3);
      cq.delete();
      wq.delete();
   endtask

   initial begin
      rst = 1'b1;
      cfg_valid = 1'b0;
      cfg_len = '0; cfg_n = '0; cfg_k = '0; cfg_m = '0;
      w_valid = 1'b0; w_data = '0; iact_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset_cfg_ready", 32'(cfg_ready), 32'd1);
      check_val("reset_busy", 32'(busy), 32'd0);
      check_val("reset_done", 32'(done), 32'd0);
      check_val("reset_cfg_err", 32'(cfg_err), 32'd0);
      check_val("reset_ctrl", 32'(ctrl), 32'd0);
      check_val("reset_wctrl", 32'(wctrl), 32'd0);
      check_val("reset_w_ready", 32'(w_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_job(2, 2, 2, 1, 0, 0);
      run_job(2, 2, 2, 1, 1, 0);
      err_job(2, 2, 0, 1);
      run_job(3, 1, 2, 1, 0, 1);
      err_job(0, 1, 1, 1);
      err_job(64, 1, 32, 1);
      run_job(32, 1, 32, 1, 2, 0);
      rst_job();
      run_job(1, 1, 3, 2, 0, 0);
      run_job(2, 3, 2, 2, 2, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
